// File: rtl/calc_sequencer.sv
// Operand-entry and operation-sequencing core: edge-detected nibble edits,
// go-launched single/multi-cycle operations with timeout, and a result history.
module calc_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned HIST_DEPTH = 4,
    parameter logic [15:0] MULTI_MASK = 16'h00CC,
    parameter int unsigned TIMEOUT    = 64,
    localparam int unsigned NIB       = WIDTH / 4,
    localparam int unsigned HW        = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NIB-1:0]       inc_lvl,
    input  logic                 dec,
    input  logic [1:0]           opnd_sel,
    input  logic [3:0]           op,
    input  logic                 go,
    input  logic [2*WIDTH-1:0]   comb_res,
    output logic                 unit_req,
    input  logic                 unit_ack,
    input  logic [2*WIDTH-1:0]   unit_res,
    input  logic                 unit_err,
    output logic [2*WIDTH-1:0]   num1,
    output logic [WIDTH-1:0]     num2,
    output logic [2*WIDTH-1:0]   result,
    input  logic [HW-1:0]        hist_idx,
    output logic [2*WIDTH-1:0]   hist_out,
    output logic [HW:0]          hist_count,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned CW   = $clog2(TIMEOUT);
    localparam int unsigned CNTW = HW + 1;
    localparam int unsigned DW   = 2 * WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]     state, state_nxt;
    logic [NIB-1:0] inc_q;
    logic           go_q;
    logic [NIB-1:0] inc_edge;
    logic           go_edge;

    logic [DW-1:0]    pending, pending_nxt;
    logic             err_cap, err_cap_nxt;
    logic             abort, abort_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             unit_req_nxt, busy_nxt, done_nxt, err_nxt;
    logic [DW-1:0]    result_nxt;
    logic [DW-1:0]    num1_nxt;
    logic [WIDTH-1:0] num2_nxt;
    logic             push;
    logic [3:0]       step;

    logic [DW-1:0] hist [HIST_DEPTH];

    assign inc_edge = inc_lvl & ~inc_q;
    assign go_edge  = go & ~go_q;
    assign step     = dec ? 4'hF : 4'h1;

    // Per-nibble wrap-around edits; no carry between nibbles.
    always_comb begin
        num1_nxt = num1;
        num2_nxt = num2;
        if (state == S_IDLE) begin
            for (int unsigned i = 0; i < NIB; i++) begin
                if (inc_edge[i]) begin
                    case (opnd_sel)
                        2'b00:   num1_nxt[4*i +: 4]         = num1[4*i +: 4] + step;
                        2'b10:   num1_nxt[WIDTH + 4*i +: 4] = num1[WIDTH + 4*i +: 4] + step;
                        2'b01:   num2_nxt[4*i +: 4]         = num2[4*i +: 4] + step;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        err_cap_nxt  = err_cap;
        abort_nxt    = abort;
        cnt_nxt      = cnt;
        unit_req_nxt = unit_req;
        done_nxt     = 1'b0;
        err_nxt      = err;
        result_nxt   = result;
        push         = 1'b0;
        case (state)
            S_IDLE: begin
                if (go_edge) begin
                    err_nxt   = 1'b0;
                    abort_nxt = 1'b0;
                    if (MULTI_MASK[op]) begin
                        unit_req_nxt = 1'b1;
                        cnt_nxt      = '0;
                        state_nxt    = S_WAIT;
                    end else begin
                        pending_nxt = comb_res;
                        err_cap_nxt = 1'b0;
                        state_nxt   = S_COMMIT;
                    end
                end
            end
            S_WAIT: begin
                if (unit_ack) begin
                    pending_nxt  = unit_res;
                    err_cap_nxt  = unit_err;
                    unit_req_nxt = 1'b0;
                    state_nxt    = S_COMMIT;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    unit_req_nxt = 1'b0;
                    abort_nxt    = 1'b1;
                    state_nxt    = S_COMMIT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_COMMIT: begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
                if (abort) begin
                    err_nxt = 1'b1;
                end else begin
                    push       = 1'b1;
                    result_nxt = pending;
                    err_nxt    = err_cap;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            inc_q      <= '0;
            go_q       <= 1'b0;
            pending    <= '0;
            err_cap    <= 1'b0;
            abort      <= 1'b0;
            cnt        <= '0;
            unit_req   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
            num1       <= '0;
            num2       <= '0;
            hist_count <= '0;
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            inc_q    <= inc_lvl;
            go_q     <= go;
            pending  <= pending_nxt;
            err_cap  <= err_cap_nxt;
            abort    <= abort_nxt;
            cnt      <= cnt_nxt;
            unit_req <= unit_req_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            result   <= result_nxt;
            num1     <= num1_nxt;
            num2     <= num2_nxt;
            if (push) begin
                hist[0] <= result;
                for (int unsigned i = HIST_DEPTH - 1; i > 0; i--) begin
                    hist[i] <= hist[i-1];
                end
                if (hist_count != CNTW'(HIST_DEPTH)) begin
                    hist_count <= hist_count + CNTW'(1);
                end
            end
        end
    end

    // Entries past the valid count read as zero.
    always_comb begin
        hist_out = '0;
        if ({1'b0, hist_idx} < hist_count) begin
            hist_out = hist[hist_idx];
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer (WIDTH=32, HIST_DEPTH=4, TIMEOUT=64).
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inc_lvl;
    logic        dec;
    logic [1:0]  opnd_sel;
    logic [3:0]  op;
    logic        go;
    logic [63:0] comb_res;
    logic        unit_req;
    logic        unit_ack;
    logic [63:0] unit_res;
    logic        unit_err;
    logic [63:0] num1;
    logic [31:0] num2;
    logic [63:0] result;
    logic [1:0]  hist_idx;
    logic [63:0] hist_out;
    logic [2:0]  hist_count;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    calc_sequencer dut (
        .clk(clk), .rst(rst), .inc_lvl(inc_lvl), .dec(dec), .opnd_sel(opnd_sel),
        .op(op), .go(go), .comb_res(comb_res), .unit_req(unit_req), .unit_ack(unit_ack),
        .unit_res(unit_res), .unit_err(unit_err), .num1(num1), .num2(num2),
        .result(result), .hist_idx(hist_idx), .hist_out(hist_out),
        .hist_count(hist_count), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (num1 !== 64'h0) begin errors++; $display("FAIL reset_num1: got %h want 0", num1); end
        checks++; if (num2 !== 32'h0) begin errors++; $display("FAIL reset_num2: got %h want 0", num2); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL reset_hist_count: got %0d want 0", hist_count); end
        checks++; if ({unit_req, busy, done, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: req/busy/done/err=%b want 0000", {unit_req, busy, done, err}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nibble_wrap();
        opnd_sel = 2'b00; dec = 1'b0;
        for (int p = 0; p < 17; p++) begin
            inc_lvl = 8'h01;
            @(negedge clk);
            if (p == 0) begin
                checks++; if (num1 !== 64'h1) begin errors++; $display("FAIL edit_latency: num1=%h want 1", num1); end
            end
            inc_lvl = 8'h00;
            @(negedge clk);
        end
        checks++; if (num1 !== 64'h1) begin errors++; $display("FAIL nibble_wrap: num1=%h want %h", num1, 64'h1); end
    endtask

    task automatic test_multi_nibble();
        opnd_sel = 2'b01; dec = 1'b1; inc_lvl = 8'h81;
        @(negedge clk);
        inc_lvl = 8'h00;
        checks++; if (num2 !== 32'hF000000F) begin errors++; $display("FAIL multi_nibble_dec: num2=%h want F000000F", num2); end
        @(negedge clk);
        opnd_sel = 2'b10; dec = 1'b0; inc_lvl = 8'h04;
        @(negedge clk);
        inc_lvl = 8'h00;
        checks++; if (num1 !== 64'h00000100_00000001) begin errors++; $display("FAIL upper_half_edit: num1=%h want 0000010000000001", num1); end
        @(negedge clk);
        opnd_sel = 2'b11; inc_lvl = 8'hFF;
        @(negedge clk);
        inc_lvl = 8'h00;
        checks++; if (num1 !== 64'h00000100_00000001 || num2 !== 32'hF000000F) begin errors++; $display("FAIL sel11_no_edit: num1=%h num2=%h unchanged values expected", num1, num2); end
        @(negedge clk);
        opnd_sel = 2'b01;
    endtask

    task automatic test_single_cycle();
        op = 4'd0; comb_res = 64'h5; go = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_launch: busy=%b done=%b want 1 0", busy, done); end
        go = 1'b0; comb_res = 64'hDEAD;
        @(negedge clk);
        checks++; if (result !== 64'h5) begin errors++; $display("FAIL single_result: got %h want 5", result); end
        checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL single_done: done=%b busy=%b err=%b want 1 0 0", done, busy, err); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b want 0", done); end
        op = 4'd8; comb_res = 64'h9; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        hist_idx = 2'd0;
        #1;
        checks++; if (result !== 64'h9) begin errors++; $display("FAIL single_op8: result=%h want 9", result); end
        checks++; if (hist_out !== 64'h5) begin errors++; $display("FAIL hist0_after_two: got %h want 5", hist_out); end
        checks++; if (hist_count !== 3'd2) begin errors++; $display("FAIL hist_count_two: got %0d want 2", hist_count); end
    endtask

    task automatic test_multi_cycle();
        logic [63:0] exp_res;
        int req_cnt;
        for (int r = 0; r < 2; r++) begin
            exp_res = (r == 0) ? 64'h00000003_00000001 : 64'h42;
            op = 4'd3; go = 1'b1; req_cnt = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (k == 0) go = 1'b0;
                if (unit_req) req_cnt++;
                if (k == 9) begin
                    unit_ack = 1'b1; unit_res = exp_res; unit_err = (r == 1);
                end
            end
            @(negedge clk);
            checks++; if (unit_req !== 1'b0) begin errors++; $display("FAIL multi_req_drop: unit_req=%b want 0", unit_req); end
            unit_ack = 1'b0; unit_res = 64'hFFFF_FFFF_FFFF_FFFF; unit_err = 1'b0;
            @(negedge clk);
            checks++; if (req_cnt !== 10) begin errors++; $display("FAIL multi_req_len: %0d cycles want 10", req_cnt); end
            checks++; if (result !== exp_res) begin errors++; $display("FAIL multi_result: got %h want %h", result, exp_res); end
            checks++; if (done !== 1'b1 || err !== (r == 1)) begin errors++; $display("FAIL multi_done_err: done=%b err=%b want 1 %0d", done, err, r); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        op = 4'd6; go = 1'b1;
        @(negedge clk);
        go = 1'b0; unit_ack = 1'b1; unit_res = 64'hAA;
        @(negedge clk);
        unit_ack = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1 || result !== 64'hAA) begin errors++; $display("FAIL b2b_first: done=%b result=%h want 1 AA", done, result); end
        op = 4'd0; comb_res = 64'h77; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_launch: busy=%b want 1", busy); end
        @(negedge clk);
        checks++; if (result !== 64'h77 || done !== 1'b1) begin errors++; $display("FAIL b2b_second: result=%h done=%b want 77 1", result, done); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int req_cnt;
        op = 4'd2; go = 1'b1; opnd_sel = 2'b01; dec = 1'b0; req_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0) go = 1'b0;
            if (unit_req) req_cnt++;
            if (k == 5) inc_lvl = 8'hFF;
            if (k == 6) inc_lvl = 8'h00;
            if (k == 20) go = 1'b1;
            if (k == 21) go = 1'b0;
        end
        @(negedge clk);
        checks++; if (unit_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL timeout_drop: unit_req=%b done=%b want 0 0", unit_req, done); end
        @(negedge clk);
        checks++; if (req_cnt !== 64) begin errors++; $display("FAIL timeout_req_len: %0d cycles want 64", req_cnt); end
        checks++; if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_abort: done=%b err=%b busy=%b want 1 1 0", done, err, busy); end
        checks++; if (result !== 64'h77 || hist_count !== 3'd4) begin errors++; $display("FAIL timeout_unchanged: result=%h count=%0d want 77 4", result, hist_count); end
        checks++; if (num2 !== 32'hF000000F) begin errors++; $display("FAIL edit_while_busy: num2=%h want F000000F", num2); end
        unit_ack = 1'b1; unit_res = 64'h1234;
        @(negedge clk);
        unit_ack = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || result !== 64'h77) begin errors++; $display("FAIL ack_in_idle: busy=%b result=%h want 0 77", busy, result); end
    endtask

    task automatic test_history();
        for (int v = 1; v <= 6; v++) begin
            op = 4'd0; comb_res = 64'(v); go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            @(negedge clk);
        end
        checks++; if (result !== 64'h6 || err !== 1'b0) begin errors++; $display("FAIL hist_result: result=%h err=%b want 6 0", result, err); end
        checks++; if (hist_count !== 3'd4) begin errors++; $display("FAIL hist_saturate: got %0d want 4", hist_count); end
        for (int i = 0; i < 4; i++) begin
            hist_idx = 2'(i);
            #1;
            checks++; if (hist_out !== 64'(5 - i)) begin errors++; $display("FAIL hist_entry[%0d]: got %h want %h", i, hist_out, 64'(5 - i)); end
        end
        hist_idx = 2'd0;
    endtask

    task automatic test_reset_mid_op();
        op = 4'd7; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (unit_req !== 1'b1) begin errors++; $display("FAIL mid_wait_req: unit_req=%b want 1", unit_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (unit_req !== 1'b0) begin errors++; $display("FAIL async_req_drop: unit_req=%b want 0", unit_req); end
        @(negedge clk);
        hist_idx = 2'd0;
        #1;
        checks++; if (num1 !== 64'h0 || num2 !== 32'h0 || result !== 64'h0) begin errors++; $display("FAIL mid_reset_regs: num1=%h num2=%h result=%h want 0", num1, num2, result); end
        checks++; if (hist_count !== 3'd0 || hist_out !== 64'h0) begin errors++; $display("FAIL mid_reset_hist: count=%0d out=%h want 0 0", hist_count, hist_out); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL mid_reset_flags: busy/done/err=%b want 000", {busy, done, err}); end
        rst = 1'b0;
        @(negedge clk);
        unit_ack = 1'b1; unit_res = 64'hBAD;
        @(negedge clk);
        unit_ack = 1'b0;
        op = 4'd0; comb_res = 64'h3C; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        checks++; if (result !== 64'h3C || hist_count !== 3'd1 || done !== 1'b1) begin errors++; $display("FAIL post_reset_op: result=%h count=%0d done=%b want 3C 1 1", result, hist_count, done); end
    endtask

    initial begin
        rst = 1'b1; inc_lvl = '0; dec = 1'b0; opnd_sel = 2'b00; op = '0; go = 1'b0;
        comb_res = '0; unit_ack = 1'b0; unit_res = '0; unit_err = 1'b0; hist_idx = '0;
        @(negedge clk);
        test_reset();
        test_nibble_wrap();
        test_multi_nibble();
        test_single_cycle();
        test_multi_cycle();
        test_back_to_back();
        test_timeout();
        test_history();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
